// File: rtl/cmn_pkg.sv
// cmn_pkg: shared helpers for index widths and one-hot to binary conversion
package cmn_pkg;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int oh2idx(input logic [63:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < 64; i++) if (oh[i]) r = r | i;
    return r;
  endfunction
endpackage

// File: rtl/cmn_rr_arb_onehot.sv
// cmn_rr_arb_onehot: one-hot grant to the first valid at or above the priority pointer, with wrap
module cmn_rr_arb_onehot
  import cmn_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int RR_EN = 1,
  parameter int IW = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] v_vld,
  input  logic [IW-1:0]    prio_ptr,
  output logic [WIDTH-1:0] grant
);
  localparam logic [2*WIDTH-1:0] ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};
  logic [IW-1:0]      p;
  logic [2*WIDTH-1:0] dbl, ff;
  // duplicate the request vector so the wrap is a plain upward scan, mask below the pointer, isolate the lowest set bit
  always_comb begin
    p = (RR_EN != 0) ? prio_ptr : '0;
    dbl = {v_vld, v_vld} & ~((ONE << p) - ONE);
    ff = dbl & (~dbl + ONE);
    grant = ff[WIDTH-1:0] | ff[2*WIDTH-1:WIDTH];
  end
endmodule

// File: rtl/cmn_rr_arb_mux_reg.sv
// cmn_rr_arb_mux_reg: arbitrated N-to-1 mux into a single-entry output register with valid/ready
module cmn_rr_arb_mux_reg
  import cmn_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int PLD_WIDTH = 32,
  parameter int RR_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     v_vld,
  output logic [WIDTH-1:0]     v_rdy,
  input  logic [PLD_WIDTH-1:0] v_pld [WIDTH-1:0],
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [PLD_WIDTH-1:0] out_pld,
  output logic [WIDTH-1:0]     out_sel
);
  localparam int IW = idx_w(WIDTH);
  logic [IW-1:0]        prio_ptr, win;
  logic [WIDTH-1:0]     grant;
  logic [PLD_WIDTH-1:0] mux;
  logic                 load, xfer;

  cmn_rr_arb_onehot #(.WIDTH(WIDTH), .RR_EN(RR_EN), .IW(IW)) u_arb (
    .v_vld(v_vld),
    .prio_ptr(prio_ptr),
    .grant(grant)
  );

  assign load = ~out_vld | out_rdy;
  assign v_rdy = grant & {WIDTH{load}};
  assign xfer = |v_rdy;
  assign win = IW'(oh2idx(64'(grant)));

  // AND-OR select so unselected payloads, even X, never reach the output
  always_comb begin
    mux = '0;
    for (int i = 0; i < WIDTH; i++) mux = mux | (v_pld[i] & {PLD_WIDTH{grant[i]}});
  end

  // pointer moves just past the winner, only on an actual transfer
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prio_ptr <= '0;
    else if (RR_EN != 0 && xfer) prio_ptr <= (win == IW'(WIDTH - 1)) ? '0 : win + 1'b1;

  // output register loads when empty or draining, otherwise holds
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_pld <= '0;
      out_sel <= '0;
    end else if (load) begin
      out_vld <= |v_vld;
      out_pld <= mux;
      out_sel <= grant;
    end
endmodule

// File: tb/tb_cmn_rr_arb_mux_reg.sv
// tb_cmn_rr_arb_mux_reg: directed checks of round-robin and fixed-priority arbitrating mux register
module tb_cmn_rr_arb_mux_reg;
  localparam int W = 4;
  localparam int P = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [W-1:0] v_vld, v_rdy, out_sel;
  logic [P-1:0] v_pld [W-1:0];
  logic         out_vld, out_rdy;
  logic [P-1:0] out_pld;
  logic [W-1:0] f_vld, f_rdy, f_sel;
  logic [P-1:0] f_pld [W-1:0];
  logic         f_ovld, f_ordy;
  logic [P-1:0] f_opld;
  int errors = 0;
  int checks = 0;

  cmn_rr_arb_mux_reg #(.WIDTH(W), .PLD_WIDTH(P), .RR_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .v_vld(v_vld), .v_rdy(v_rdy), .v_pld(v_pld),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_pld(out_pld), .out_sel(out_sel)
  );

  cmn_rr_arb_mux_reg #(.WIDTH(W), .PLD_WIDTH(P), .RR_EN(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .v_vld(f_vld), .v_rdy(f_rdy), .v_pld(f_pld),
    .out_vld(f_ovld), .out_rdy(f_ordy), .out_pld(f_opld), .out_sel(f_sel)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    v_vld = '0;
    out_rdy = 1'b0;
    f_vld = '0;
    f_ordy = 1'b1;
    for (int i = 0; i < W; i++) begin
      v_pld[i] = '0;
      f_pld[i] = 32'h200 + i;
    end
    #2;
    chk("rst_vld", out_vld, 0);
    chk("rst_pld", out_pld, 0);
    chk("rst_sel", out_sel, 0);
    tick;
    tick;
    rst_n = 1'b1;
    v_vld = 4'b1111;
    for (int i = 0; i < W; i++) v_pld[i] = 32'h100 + i;
    out_rdy = 1'b1;
    #1;
    chk("rr_rdy0", v_rdy, 4'b0001);
    for (int k = 0; k < 8; k++) begin
      tick;
      chk("rr_vld", out_vld, 1);
      chk("rr_sel", out_sel, 64'(1) << (k % 4));
      chk("rr_pld", out_pld, 32'h100 + (k % 4));
      chk("rr_rdy", v_rdy, 64'(1) << ((k + 1) % 4));
    end
    v_vld = 4'b0101;
    #1;
    chk("sp_rdy", v_rdy, 4'b0001);
    tick;
    chk("sp_sel0", out_sel, 4'b0001);
    tick;
    chk("sp_sel2", out_sel, 4'b0100);
    tick;
    chk("sp_sel0b", out_sel, 4'b0001);
    chk("sp_pld", out_pld, 32'h100);
    out_rdy = 1'b0;
    v_vld = 4'b0010;
    #1;
    chk("bp_rdy0", v_rdy, 0);
    repeat (3) begin
      tick;
      chk("bp_vld", out_vld, 1);
      chk("bp_sel", out_sel, 4'b0001);
      chk("bp_pld", out_pld, 32'h100);
      chk("bp_rdy", v_rdy, 0);
    end
    out_rdy = 1'b1;
    #1;
    chk("bp_acc", v_rdy, 4'b0010);
    tick;
    chk("bp_sel1", out_sel, 4'b0010);
    chk("bp_pld1", out_pld, 32'h101);
    v_vld = 4'b1111;
    #1;
    chk("bp_ptr", v_rdy, 4'b0100);
    v_vld = 4'b0001;
    v_pld[0] = 32'hDEAD_BEEF;
    tick;
    chk("mr_vld", out_vld, 1);
    chk("mr_pld", out_pld, 32'hDEAD_BEEF);
    out_rdy = 1'b0;
    v_vld = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_rvld", out_vld, 0);
    chk("mr_rpld", out_pld, 0);
    chk("mr_rsel", out_sel, 0);
    #2;
    rst_n = 1'b1;
    v_vld = 4'b1111;
    out_rdy = 1'b1;
    #1;
    chk("mr_rdy", v_rdy, 4'b0001);
    tick;
    chk("mr_sel", out_sel, 4'b0001);
    v_vld = '0;
    for (int i = 0; i < W; i++) v_pld[i] = 'x;
    tick;
    chk("id_vld", out_vld, 0);
    chk("id_pld", out_pld, 0);
    chk("id_sel", out_sel, 0);
    v_vld = 4'b1000;
    v_pld[3] = 32'hA5A5_A5A5;
    tick;
    chk("x_vld", out_vld, 1);
    chk("x_pld", out_pld, 32'hA5A5_A5A5);
    chk("x_sel", out_sel, 4'b1000);
    f_vld = 4'b1110;
    #1;
    chk("fp_rdy0", f_rdy, 4'b0010);
    repeat (3) begin
      tick;
      chk("fp_sel", f_sel, 4'b0010);
      chk("fp_pld", f_opld, 32'h201);
      chk("fp_rdy", f_rdy, 4'b0010);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cmn_rr_arb_mux_reg.md
Name: cmn_rr_arb_mux_reg

Overview:
- Registered N-to-1 arbitrating multiplexer with per-channel valid/ready handshake.
- Selects one requester per cycle with a one-hot grant, either round-robin or fixed-priority.
- Muxes the winner's payload into a single-entry output register that also carries the winner's one-hot index.
- Used wherever several producers share one downstream channel: issue ports, writeback buses, request queues.

Parameters:
- WIDTH, 4: number of requesting channels; minimum 1.
- PLD_WIDTH, 32: payload width in bits; minimum 1.
- RR_EN, 1: 1 = round-robin priority; 0 = fixed priority, lowest index wins.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- v_vld  input  WIDTH  per-channel request valid.
- v_rdy  output  WIDTH  per-channel accept; one-hot or zero.
- v_pld  input  PLD_WIDTH x WIDTH (unpacked array [WIDTH-1:0])  per-channel payload.
- out_vld  output  1  output register holds valid data.
- out_rdy  input  1  downstream accept.
- out_pld  output  PLD_WIDTH  registered winning payload.
- out_sel  output  WIDTH  registered one-hot index of the winning channel.

Behaviour:
- Reset:
  - One clock; reset asynchronous, active-low: rst_n low immediately forces out_vld=0, out_pld=0, out_sel=0, prio_ptr=0 (channel 0 highest priority).
  - Takes effect mid-transfer; any held output is dropped without a handshake.
- Load enable: load = ~out_vld | out_rdy (register empty, or draining this cycle).
- Grant, combinational from v_vld and prio_ptr:
  - One-hot grant to the first asserted v_vld bit, scanning upward from prio_ptr with wrap from WIDTH-1 to 0.
  - With RR_EN=0, the scan always starts at 0.
  - grant = 0 when v_vld = 0.
- Accept:
  - v_rdy = grant & {WIDTH{load}}.
  - A channel transfer occurs on v_vld[i] & v_rdy[i].
  - At most one transfer per cycle.
  - v_rdy may depend combinationally on v_vld. Producers must not make v_vld depend on v_rdy.
- Payload mux:
  - AND-OR one-hot select: each payload bit is the OR over channels of v_pld[i][bit] & grant[i].
  - No priority chain. Output is all-zero when grant = 0.
- Output register update, on clk when load is high:
  - out_vld <= |v_vld.
  - out_pld <= muxed payload.
  - out_sel <= grant.
- Output register hold: when load is low (out_vld=1, out_rdy=0), out_vld, out_pld and out_sel hold stable.
- Pointer update: prio_ptr advances only on a channel transfer, to (winner index + 1) mod WIDTH. It holds otherwise and when RR_EN=0.
- Latency and throughput:
  - Latency 1 cycle from channel transfer to out_vld.
  - Full throughput of 1 transfer per cycle while out_rdy stays high.
  - Simultaneous drain and refill in the same cycle is required; there is no bubble.
- Fairness (RR_EN=1): with all channels continuously valid, each channel is granted exactly once every WIDTH transfers. Starvation-free.
- Backpressure: while out_rdy=0 and out_vld=1, v_rdy=0 and the grant does not change the pointer.
- WIDTH=1: degenerates to a 1-deep pipeline register. prio_ptr is constant 0 and the pointer is 1 bit wide, minimum.
- Idle: no v_vld and out_rdy=1 gives out_vld=0 next cycle. out_pld may update to 0 and is a don't-care while out_vld=0.
- No X on out_pld or out_sel after reset, even if v_pld is X on unselected channels. The AND-OR mux masks them.

Decomposition:
- Shared package cmn_pkg: the function for the index width ($clog2 with a minimum of 1) and the function for one-hot to binary index conversion.
- Sub-module cmn_rr_arb_onehot:
  - Inputs: v_vld, prio_ptr, RR_EN.
  - Output: one-hot grant.
  - Implementation: combinational, double-width mask-and-find-first.
- The top level holds prio_ptr, the AND-OR payload mux, and the output register.

Test Plan (WIDTH=4, PLD_WIDTH=32, RR_EN=1 unless stated):
- Reset mid-operation: out_vld=1 holding 0xDEAD_BEEF, assert rst_n=0 between clock edges -> out_vld=0, out_pld=0, out_sel=0 without waiting for a clock edge; first grant after release goes to channel 0.
- Round-robin: v_vld=4'b1111 constant, v_pld[i]=0x100+i, out_rdy=1 -> out_sel sequence 0001,0010,0100,1000,0001; out_pld 0x100,0x101,0x102,0x103,0x100; one transfer per cycle.
- Sparse wrap: after a grant to channel 3, v_vld=4'b0101 -> channel 0 granted, then channel 2, then channel 0; the pointer skips invalid channels.
- Backpressure: out_vld=1, out_rdy=0 for 3 cycles while v_vld=4'b0010 -> v_rdy=0, out_pld/out_sel stable and pointer frozen; when out_rdy rises, channel 1 is accepted in that same cycle and out_sel=0010 on the next cycle.
- Fixed priority (RR_EN=0): v_vld=4'b1110 for 3 cycles -> channel 1 granted every cycle; channels 2 and 3 never see v_rdy.
- Idle and X masking: v_vld=0, v_pld=X, out_rdy=1 -> out_vld=0 and no X on out_pld or out_sel. Then v_vld=4'b1000, v_pld[3]=0xA5A5_A5A5 -> out_pld=0xA5A5_A5A5 next cycle.
